reg_fifo_master: RTL and testbench
==================================

Name: reg_fifo_master

Overview:
- Consumer end of the CPU register FIFO interface.
- Pops queued register accesses (rd_wr_L, addr, wr_data) from the register write FIFO.
- Drives each access as a single request/acknowledge transaction on the core register bus.
- For read accesses, pushes the returned data back into the register read FIFO via reg_rd_data/reg_rd_vld.

Parameters:
- ADDR_WIDTH, 27, register address width; equals CPCI_NF2_ADDR_WIDTH.
- DATA_WIDTH, 32, register data width; equals CPCI_NF2_DATA_WIDTH.
- TIMEOUT_CYCLES, 1023, cycles to wait for core_reg_ack before abandoning an access (used only with the optional feature).
- ERROR_DATA, 32'hDEAD_DEAD, read data returned on timeout.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- reg_fifo_empty  in  1  register write FIFO empty.
- reg_fifo_rd_en  out  1  pop request to the register write FIFO.
- reg_rd_wr_L  in  1  popped entry type: 1 = read, 0 = write.
- reg_addr  in  ADDR_WIDTH  popped entry address.
- reg_wr_data  in  DATA_WIDTH  popped entry write data.
- reg_rd_data  out  DATA_WIDTH  read result sent to the register read FIFO.
- reg_rd_vld  out  1  write strobe for the register read FIFO.
- core_reg_req  out  1  core bus request.
- core_reg_rd_wr_L  out  1  core bus direction.
- core_reg_addr  out  ADDR_WIDTH  core bus address.
- core_reg_wr_data  out  DATA_WIDTH  core bus write data.
- core_reg_rd_data  in  DATA_WIDTH  core bus read data; valid while core_reg_ack = 1.
- core_reg_ack  in  1  core bus acknowledge, single-cycle pulse.
- busy  out  1  high whenever the state is not IDLE.
- access_cnt  out  16  completed accesses; wraps.
- timeout_cnt  out  16  timed-out accesses; saturates at 16'hFFFF.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE.
  - All outputs 0: reg_fifo_rd_en, reg_rd_vld, reg_rd_data, core_reg_*, busy, both counters.
  - An in-flight access is dropped without response. The popped FIFO entry is lost; this is the accepted behaviour.
- The FIFO has registered outputs: the entry fields are valid the cycle after reg_fifo_rd_en is asserted.
- reg_fifo_rd_en is combinational: equals (state == IDLE) && !reg_fifo_empty. It is never asserted in any other state.
- FSM:
  - IDLE: if !reg_fifo_empty, pop the FIFO and go to LATCH.
  - LATCH: register reg_rd_wr_L, reg_addr, reg_wr_data into core_reg_rd_wr_L, core_reg_addr, core_reg_wr_data. Set core_reg_req = 1. Go to WAIT_ACK.
  - WAIT_ACK: hold core_reg_req and all core_reg_* fields stable until core_reg_ack = 1. On the ack cycle:
    - core_reg_req goes to 0 on the next edge.
    - access_cnt increments.
    - If the access is a read: reg_rd_data <= core_reg_rd_data and reg_rd_vld <= 1 on the next edge.
    - Go to DONE.
  - DONE: reg_rd_vld returns to 0 (it is a one-cycle pulse). Go to IDLE.
- Minimum latency from the pop cycle to the reg_rd_vld pulse is 3 cycles with a zero-wait ack. Minimum back-to-back spacing is 4 cycles per access; an idle gap between requests is guaranteed.
- Writes never assert reg_rd_vld.
- core_reg_ack in any state other than WAIT_ACK is ignored.
- core_reg_ack arriving on the same edge as the timeout: the ack wins and the access completes normally.

Optional Feature:
- Macro: REG_FIFO_MASTER_TIMEOUT_EN.
- When defined:
  - A 10-bit wait counter clears on entry to WAIT_ACK.
  - If it reaches TIMEOUT_CYCLES without an ack, core_reg_req drops and the access completes as if acknowledged.
  - Reads return ERROR_DATA with a reg_rd_vld pulse.
  - timeout_cnt increments (saturating); access_cnt also increments.
- When undefined: WAIT_ACK waits indefinitely and timeout_cnt is tied to 0.

Decomposition:
- Shared package holds:
  - state encodings IDLE = 2'd0, LATCH = 2'd1, WAIT_ACK = 2'd2, DONE = 2'd3;
  - default ERROR_DATA;
  - counter width 16.
- Address and data widths come from the existing CPCI_NF2 width defines.
- One sub-module: reg_fifo_master_timer (wait counter plus timeout flag); instantiated only under the macro.

Test Plan:
- Write: FIFO holds {0, 27'h0000040, 32'h1234_5678}; ack after 2 cycles -> core_reg_req high for 3 cycles with those fields; no reg_rd_vld; access_cnt = 1.
- Read: FIFO holds {1, 27'h0000044}; ack with core_reg_rd_data = 32'hCAFE_F00D -> one-cycle reg_rd_vld with reg_rd_data = 32'hCAFE_F00D; access_cnt increments.
- Back-to-back: 3 entries, zero-wait ack -> exactly 3 reg_fifo_rd_en pulses spaced 4 cycles apart; core_reg_req deasserted at least 1 cycle between requests.
- Timeout (macro on, TIMEOUT_CYCLES = 8): read, no ack -> core_reg_req drops after 8 cycles; reg_rd_data = 32'hDEAD_DEAD; timeout_cnt = 1.
- Reset mid-access: assert reset during WAIT_ACK -> all outputs 0 immediately (asynchronous); after release with FIFO empty, stays IDLE with no core_reg_req.
- Stray ack in IDLE: no state change, no counter change, no reg_rd_vld.

Source files
------------

// File: rtl/reg_fifo_master_pkg.sv
// ---------------------------------------------------------------------------
// reg_fifo_master_pkg
// Shared definitions for the register FIFO master:
//   - FSM state encoding
//   - statistics counter width
//   - default read data returned when an access times out
//   - default address/data widths, taken from the CPCI_NF2 width defines
//     (fallback values are supplied when those defines are not present)
// ---------------------------------------------------------------------------
`ifndef CPCI_NF2_ADDR_WIDTH
`define CPCI_NF2_ADDR_WIDTH 27
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

package reg_fifo_master_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LATCH    = 2'd1,
        WAIT_ACK = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int CNT_WIDTH          = 16;
    localparam int DEFAULT_ADDR_WIDTH = `CPCI_NF2_ADDR_WIDTH;
    localparam int DEFAULT_DATA_WIDTH = `CPCI_NF2_DATA_WIDTH;

    localparam logic [31:0] DEFAULT_ERROR_DATA = 32'hDEAD_DEAD;

endpackage

// File: rtl/reg_fifo_master_if.sv
// ---------------------------------------------------------------------------
// reg_fifo_master_if
// Bundles the register write/read FIFO signals and the core register bus.
//   modport master : the reg_fifo_master block (pops FIFO, drives core bus)
//   modport slave  : the environment (FIFOs and core register decoder)
// Signals:
//   reg_fifo_empty / reg_fifo_rd_en          write FIFO status / pop
//   reg_rd_wr_L, reg_addr, reg_wr_data       popped entry (1 = read)
//   reg_rd_data / reg_rd_vld                 read FIFO data / write strobe
//   core_reg_req, core_reg_rd_wr_L,
//   core_reg_addr, core_reg_wr_data          core bus request
//   core_reg_rd_data / core_reg_ack          core bus response
// ---------------------------------------------------------------------------
interface reg_fifo_master_if #(
    parameter int ADDR_WIDTH = reg_fifo_master_pkg::DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = reg_fifo_master_pkg::DEFAULT_DATA_WIDTH
);

    logic                  reg_fifo_empty;
    logic                  reg_fifo_rd_en;
    logic                  reg_rd_wr_L;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] reg_wr_data;
    logic [DATA_WIDTH-1:0] reg_rd_data;
    logic                  reg_rd_vld;

    logic                  core_reg_req;
    logic                  core_reg_rd_wr_L;
    logic [ADDR_WIDTH-1:0] core_reg_addr;
    logic [DATA_WIDTH-1:0] core_reg_wr_data;
    logic [DATA_WIDTH-1:0] core_reg_rd_data;
    logic                  core_reg_ack;

    modport master (
        input  reg_fifo_empty, reg_rd_wr_L, reg_addr, reg_wr_data,
               core_reg_rd_data, core_reg_ack,
        output reg_fifo_rd_en, reg_rd_data, reg_rd_vld,
               core_reg_req, core_reg_rd_wr_L, core_reg_addr, core_reg_wr_data
    );

    modport slave (
        output reg_fifo_empty, reg_rd_wr_L, reg_addr, reg_wr_data,
               core_reg_rd_data, core_reg_ack,
        input  reg_fifo_rd_en, reg_rd_data, reg_rd_vld,
               core_reg_req, core_reg_rd_wr_L, core_reg_addr, core_reg_wr_data
    );

endinterface

// File: rtl/reg_fifo_master_timer.sv
// ---------------------------------------------------------------------------
// reg_fifo_master_timer
// Wait counter for the WAIT_ACK state. Built only when
// REG_FIFO_MASTER_TIMEOUT_EN is defined.
// Ports:
//   clk, reset  clock / asynchronous active-low reset
//   clear       restart the count (asserted in the cycle before WAIT_ACK)
//   run         count this cycle (asserted while in WAIT_ACK)
//   timed_out   high in the TIMEOUT_CYCLES-th consecutive WAIT_ACK cycle
// ---------------------------------------------------------------------------
`ifdef REG_FIFO_MASTER_TIMEOUT_EN
module reg_fifo_master_timer #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic timed_out
);

    localparam int TIMER_WIDTH = 10;
    // Count starts at 0 in the first wait cycle, so the last allowed wait
    // cycle sees TIMEOUT_CYCLES-1.
    localparam logic [TIMER_WIDTH-1:0] LIMIT = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMER_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign timed_out = run && (cnt == LIMIT);

endmodule
`endif

// File: rtl/reg_fifo_master.sv
// ---------------------------------------------------------------------------
// reg_fifo_master
// Consumer end of the CPU register FIFO. Pops one queued access at a time,
// runs it as a single req/ack transaction on the core register bus and, for
// reads, writes the returned data into the register read FIFO.
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   bus          reg_fifo_master_if.master (FIFO + core bus signals)
//   busy         high whenever the FSM is not IDLE
//   access_cnt   completed accesses (wraps)
//   timeout_cnt  timed-out accesses (saturates); 0 when timeouts are off
// Build option:
//   REG_FIFO_MASTER_TIMEOUT_EN  abandon an access after TIMEOUT_CYCLES wait
//                               cycles without ack; reads return ERROR_DATA.
// ---------------------------------------------------------------------------
module reg_fifo_master
    import reg_fifo_master_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int                    DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int                    TIMEOUT_CYCLES = 1023,
    parameter logic [DATA_WIDTH-1:0] ERROR_DATA     = DATA_WIDTH'(DEFAULT_ERROR_DATA)
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_fifo_master_if.master    bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] access_cnt,
    output logic [CNT_WIDTH-1:0] timeout_cnt
);

    state_t state;
    state_t state_next;
    logic   timed_out;
    logic   latch_en;
    logic   complete;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            // NOTE: all sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of process order.
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (!bus.reg_fifo_empty) state_next = LATCH;
            LATCH:    state_next = WAIT_ACK;
            WAIT_ACK: if (bus.core_reg_ack || timed_out) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs and datapath strobes
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        bus.reg_fifo_rd_en = 1'b0;
        busy               = 1'b1;
        latch_en           = 1'b0;
        complete           = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                // NOTE: gated with reset so the pop request is low while
                // reset is held, even though state already reads IDLE.
                bus.reg_fifo_rd_en = reset && !bus.reg_fifo_empty;
            end
            LATCH:    latch_en = 1'b1;
            // An ack coinciding with the timeout still completes normally.
            WAIT_ACK: complete = bus.core_reg_ack || timed_out;
            default:  ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Core bus request, read-FIFO write and access counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.core_reg_req     <= 1'b0;
            bus.core_reg_rd_wr_L <= 1'b0;
            bus.core_reg_addr    <= '0;
            bus.core_reg_wr_data <= '0;
            bus.reg_rd_data      <= '0;
            bus.reg_rd_vld       <= 1'b0;
            access_cnt           <= '0;
        end else begin
            // One-cycle strobe into the read FIFO.
            bus.reg_rd_vld <= 1'b0;

            // FIFO entry fields are valid in LATCH (registered FIFO outputs).
            if (latch_en) begin
                bus.core_reg_req     <= 1'b1;
                bus.core_reg_rd_wr_L <= bus.reg_rd_wr_L;
                bus.core_reg_addr    <= bus.reg_addr;
                bus.core_reg_wr_data <= bus.reg_wr_data;
            end

            if (complete) begin
                bus.core_reg_req <= 1'b0;
                access_cnt       <= access_cnt + 1'b1;
                if (bus.core_reg_rd_wr_L) begin
                    bus.reg_rd_vld  <= 1'b1;
                    bus.reg_rd_data <= bus.core_reg_ack ? bus.core_reg_rd_data
                                                        : ERROR_DATA;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Optional ack timeout
    // -----------------------------------------------------------------------
`ifdef REG_FIFO_MASTER_TIMEOUT_EN
    reg_fifo_master_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == LATCH),
        .run       (state == WAIT_ACK),
        .timed_out (timed_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_cnt <= '0;
        end else if (timed_out && !bus.core_reg_ack && timeout_cnt != '1) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end
`else
    // Without the timer WAIT_ACK waits for the ack indefinitely.
    logic [31:0] unused_timeout_cycles;

    assign timed_out             = 1'b0;
    assign timeout_cnt           = '0;
    assign unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_reg_fifo_master.sv
// ---------------------------------------------------------------------------
// tb_reg_fifo_master
// Directed bench for reg_fifo_master. A FIFO model with registered outputs
// feeds entries, a responder acks core bus requests after a programmable
// number of wait cycles, and a monitor compares every core request and every
// read-FIFO write against expectations queued by the stimulus.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_fifo_master;

    localparam int AW        = 27;
    localparam int DW        = 32;
    localparam int TO_CYCLES = 8;
`ifdef REG_FIFO_MASTER_TIMEOUT_EN
    localparam int HOLD_CYCLES = 4;
`else
    localparam int HOLD_CYCLES = 20;
`endif

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          busy;
    logic [15:0]   access_cnt;
    logic [15:0]   timeout_cnt;

    reg_fifo_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    reg_fifo_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO_CYCLES),
        .ERROR_DATA     (32'hDEAD_DEAD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .access_cnt  (access_cnt),
        .timeout_cnt (timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rd_wr_L;
        logic [AW-1:0] addr;
        logic [DW-1:0] wr_data;
    } entry_t;

    typedef struct {
        entry_t e;
        int     dur;   // expected req high cycles, -1 = not checked
    } exp_req_t;

    typedef struct {
        logic [DW-1:0] data;
        int            lat;  // pop-to-vld cycles, -1 = not checked
    } exp_rd_t;

    entry_t   fifo_q[$];
    exp_req_t exp_req_q[$];
    exp_rd_t  exp_rd_q[$];
    int       pop_cycles[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_pop    = 0;

    logic          ack_en     = 1'b0;
    int            ack_wait   = 0;
    logic          ack_resp   = 1'b0;
    logic          ack_stray  = 1'b0;
    logic [DW-1:0] resp_base  = '0;
    logic [DW-1:0] resp_data  = '0;
    logic [DW-1:0] stray_data = '0;

    assign bus.core_reg_ack     = ack_resp | ack_stray;
    assign bus.core_reg_rd_data = ack_stray ? stray_data : resp_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_access(input logic rd_wr_L, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wr_data, input int dur);
        entry_t   e;
        exp_req_t r;
        e.rd_wr_L = rd_wr_L;
        e.addr    = addr;
        e.wr_data = wr_data;
        r.e       = e;
        r.dur     = dur;
        fifo_q.push_back(e);
        exp_req_q.push_back(r);
    endtask

    task automatic push_read_result(input logic [DW-1:0] data, input int lat);
        exp_rd_t d;
        d.data = data;
        d.lat  = lat;
        exp_rd_q.push_back(d);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while ((fifo_q.size() != 0 || !bus.reg_fifo_empty || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_completes"}, 64'(n < 200), 64'd1);
    endtask

    // Register write FIFO model: fields appear the cycle after the pop.
    initial begin
        logic   pop;
        entry_t e;
        bus.reg_fifo_empty = 1'b1;
        bus.reg_rd_wr_L    = 1'b0;
        bus.reg_addr       = '0;
        bus.reg_wr_data    = '0;
        forever begin
            @(negedge clk);
            pop = bus.reg_fifo_rd_en;
            @(posedge clk);
            #1;
            if (pop && fifo_q.size() > 0) begin
                e = fifo_q.pop_front();
                bus.reg_rd_wr_L = e.rd_wr_L;
                bus.reg_addr    = e.addr;
                bus.reg_wr_data = e.wr_data;
            end
            bus.reg_fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Core bus responder: ack after ack_wait cycles of req; data = base ^ addr.
    initial begin
        int seen = 0;
        forever begin
            @(negedge clk);
            if (bus.core_reg_req) begin
                seen++;
                ack_resp = ack_en && (seen == ack_wait + 1);
                if (ack_resp) resp_data = resp_base ^ DW'(bus.core_reg_addr);
            end else begin
                seen     = 0;
                ack_resp = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic     prev_req = 1'b0;
        logic     prev_vld = 1'b0;
        logic     stable   = 1'b1;
        int       req_len  = 0;
        int       cur_dur  = -1;
        exp_req_t er;
        exp_rd_t  ed;
        entry_t   cur;
        cur = '{rd_wr_L: 1'b0, addr: '0, wr_data: '0};
        forever begin
            @(negedge clk);
            if (bus.reg_fifo_rd_en) begin
                pop_cycles.push_back(cyc);
                last_pop = cyc;
            end
            if (bus.core_reg_req && !prev_req) begin
                req_len = 0;
                stable  = 1'b1;
                cur_dur = -1;
                if (exp_req_q.size() == 0) begin
                    check("unexpected_req", 64'(bus.core_reg_req), 64'd0);
                end else begin
                    er      = exp_req_q.pop_front();
                    cur     = er.e;
                    cur_dur = er.dur;
                    check("req_rd_wr_L", 64'(bus.core_reg_rd_wr_L), 64'(er.e.rd_wr_L));
                    check("req_addr", 64'(bus.core_reg_addr), 64'(er.e.addr));
                    check("req_wr_data", 64'(bus.core_reg_wr_data), 64'(er.e.wr_data));
                end
            end
            if (bus.core_reg_req) begin
                req_len++;
                if (bus.core_reg_rd_wr_L !== cur.rd_wr_L || bus.core_reg_addr !== cur.addr ||
                    bus.core_reg_wr_data !== cur.wr_data)
                    stable = 1'b0;
            end
            if (!bus.core_reg_req && prev_req && cur_dur >= 0) begin
                check("req_len", 64'(req_len), 64'(cur_dur));
                check("req_fields_stable", 64'(stable), 64'd1);
            end
            if (bus.reg_rd_vld) begin
                check("rd_vld_single_cycle", 64'(prev_vld), 64'd0);
                if (exp_rd_q.size() == 0) begin
                    check("unexpected_rd_vld", 64'(bus.reg_rd_vld), 64'd0);
                end else begin
                    ed = exp_rd_q.pop_front();
                    check("rd_data", 64'(bus.reg_rd_data), 64'(ed.data));
                    if (ed.lat >= 0) check("rd_latency", 64'(cyc - last_pop), 64'(ed.lat));
                end
            end
            prev_req = bus.core_reg_req;
            prev_vld = bus.reg_rd_vld;
        end
    end

    // Stimulus.
    initial begin
        int n;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req", 64'(bus.core_reg_req), 64'd0);
        check("rst_rd_en", 64'(bus.reg_fifo_rd_en), 64'd0);
        check("rst_rd_vld", 64'(bus.reg_rd_vld), 64'd0);
        check("rst_access_cnt", 64'(access_cnt), 64'd0);
        check("rst_timeout_cnt", 64'(timeout_cnt), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Write, ack after 2 wait cycles: req high 3 cycles, no rd_vld.
        ack_en   = 1'b1;
        ack_wait = 2;
        push_access(1'b0, 27'h0000040, 32'h1234_5678, 3);
        wait_idle("write");
        check("write_access_cnt", 64'(access_cnt), 64'd1);

        // Read, zero-wait ack.
        ack_wait  = 0;
        resp_base = 32'hCAFE_F049;   // ^ 27'h44 -> 32'hCAFE_F00D
        push_access(1'b1, 27'h0000044, 32'h0, 1);
        push_read_result(32'hCAFE_F00D, 3);
        wait_idle("read");
        check("read_access_cnt", 64'(access_cnt), 64'd2);

        // Back-to-back: three pops spaced 4 cycles apart.
        pop_cycles.delete();
        resp_base = 32'h5A5A_0000;
        push_access(1'b0, 27'h0000100, 32'hA5A5_0001, 1);
        push_access(1'b1, 27'h0000104, 32'h0, 1);
        push_read_result(32'h5A5A_0104, 3);
        push_access(1'b1, 27'h0000108, 32'h0, 1);
        push_read_result(32'h5A5A_0108, 3);
        wait_idle("b2b");
        check("b2b_pop_count", 64'(pop_cycles.size()), 64'd3);
        if (pop_cycles.size() == 3) begin
            check("b2b_spacing_0", 64'(pop_cycles[1] - pop_cycles[0]), 64'd4);
            check("b2b_spacing_1", 64'(pop_cycles[2] - pop_cycles[1]), 64'd4);
        end
        check("b2b_access_cnt", 64'(access_cnt), 64'd5);

        // Stray ack while idle: ignored.
        stray_data = 32'hFFFF_FFFF;
        ack_stray  = 1'b1;
        @(negedge clk);
        ack_stray  = 1'b0;
        @(negedge clk);
        check("stray_busy", 64'(busy), 64'd0);
        check("stray_req", 64'(bus.core_reg_req), 64'd0);
        check("stray_access_cnt", 64'(access_cnt), 64'd5);

`ifdef REG_FIFO_MASTER_TIMEOUT_EN
        // Read with no ack: abandoned after TO_CYCLES wait cycles.
        ack_en = 1'b0;
        push_access(1'b1, 27'h0000048, 32'h0, TO_CYCLES);
        push_read_result(32'hDEAD_DEAD, TO_CYCLES + 2);
        wait_idle("timeout");
        check("timeout_cnt", 64'(timeout_cnt), 64'd1);
        check("timeout_access_cnt", 64'(access_cnt), 64'd6);
`else
        check("timeout_cnt_tied", 64'(timeout_cnt), 64'd0);
`endif

        // Reset in the middle of WAIT_ACK.
        ack_en = 1'b0;
        push_access(1'b1, 27'h000004C, 32'h0, -1);
        n = 0;
        while (!bus.core_reg_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midrst_req_seen", 64'(bus.core_reg_req), 64'd1);
        repeat (HOLD_CYCLES) @(negedge clk);
        check("midrst_wait_busy", 64'(busy), 64'd1);
        check("midrst_wait_req", 64'(bus.core_reg_req), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_req", 64'(bus.core_reg_req), 64'd0);
        check("midrst_rd_wr_L", 64'(bus.core_reg_rd_wr_L), 64'd0);
        check("midrst_addr", 64'(bus.core_reg_addr), 64'd0);
        check("midrst_wr_data", 64'(bus.core_reg_wr_data), 64'd0);
        check("midrst_rd_data", 64'(bus.reg_rd_data), 64'd0);
        check("midrst_rd_vld", 64'(bus.reg_rd_vld), 64'd0);
        check("midrst_rd_en", 64'(bus.reg_fifo_rd_en), 64'd0);
        check("midrst_access_cnt", 64'(access_cnt), 64'd0);
        check("midrst_timeout_cnt", 64'(timeout_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("postrst_busy", 64'(busy), 64'd0);
        check("postrst_req", 64'(bus.core_reg_req), 64'd0);
        check("postrst_rd_en", 64'(bus.reg_fifo_rd_en), 64'd0);

        check("exp_req_drained", 64'(exp_req_q.size()), 64'd0);
        check("exp_rd_drained", 64'(exp_rd_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected under 20000", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
